// File: rtl/ddr_mem_responder_if.sv
// Cache-side DDR command/response bundle.
// The initiator drives the command; the responder drives ready and read data.
interface ddr_mem_responder_if;
    logic         mem_valid_data1;
    logic         mem_rw_data1;
    logic [27:0]  mem_data_addr1;
    logic [255:0] mem_data_wr1;
    logic [255:0] mem_data_rd1;
    logic         mem_ready_data1;

    modport master (
        output mem_valid_data1,
        output mem_rw_data1,
        output mem_data_addr1,
        output mem_data_wr1,
        input  mem_data_rd1,
        input  mem_ready_data1
    );

    modport slave (
        input  mem_valid_data1,
        input  mem_rw_data1,
        input  mem_data_addr1,
        input  mem_data_wr1,
        output mem_data_rd1,
        output mem_ready_data1
    );
endinterface

// File: rtl/ddr_mem_responder.sv
// Behavioural DDR2 responder: one command at a time, 256-bit line array,
// registered one-cycle ready pulse after a programmable delay.
module ddr_mem_responder #(
    parameter int CYCLE_DELAY = 1,
    parameter int DEPTH       = 1024
) (
    input  logic                clk,
    input  logic                rst,
    ddr_mem_responder_if.slave  bus,
    output logic [15:0]         wr_count,
    output logic                oob_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CYCLE_DELAY > 1) ? $clog2(CYCLE_DELAY) + 1 : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(CYCLE_DELAY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            rw_q;
    logic [27:3]     line_q;
    logic [255:0]    data_q;
    logic            cmd_rw;
    logic [27:3]     cmd_line;
    logic [255:0]    cmd_data;
    logic            accept;
    logic            go_resp;
    logic            in_range;
    logic [AW-1:0]   idx;
    logic            unused;
    logic [255:0]    mem [DEPTH];

    assign unused = ^bus.mem_data_addr1[2:0];

    // In IDLE the command is taken straight from the bus so a one-cycle
    // delay can commit on the capture edge; later it comes from the latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        go_resp   = 1'b0;
        cmd_rw    = rw_q;
        cmd_line  = line_q;
        cmd_data  = data_q;
        unique case (state)
            IDLE: begin
                if (bus.mem_valid_data1) begin
                    accept   = 1'b1;
                    cmd_rw   = bus.mem_rw_data1;
                    cmd_line = bus.mem_data_addr1[27:3];
                    cmd_data = bus.mem_data_wr1;
                    if (CYCLE_DELAY == 1) begin
                        go_resp   = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    go_resp   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign idx      = cmd_line[3 +: AW];
    assign in_range = (cmd_line[27:3+AW] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            cnt                 <= '0;
            bus.mem_ready_data1 <= 1'b0;
            bus.mem_data_rd1    <= '0;
            wr_count            <= '0;
            oob_err             <= 1'b0;
        end else begin
            state               <= state_nxt;
            cnt                 <= cnt_nxt;
            bus.mem_ready_data1 <= go_resp;
            if (go_resp) begin
                if (cmd_rw) begin
                    wr_count <= wr_count + 16'd1;
                end else begin
                    bus.mem_data_rd1 <= in_range ? mem[idx] : '0;
                end
                if (!in_range) begin
                    oob_err <= 1'b1;
                end
            end
        end
    end

    // Line array and command latch carry no reset; rst gates the commit.
    always_ff @(posedge clk) begin
        if (accept) begin
            rw_q   <= bus.mem_rw_data1;
            line_q <= bus.mem_data_addr1[27:3];
            data_q <= bus.mem_data_wr1;
        end
        if (rst && go_resp && cmd_rw && in_range) begin
            mem[idx] <= cmd_data;
        end
    end
endmodule

// File: tb/tb_ddr_mem_responder.sv
// Directed bench for ddr_mem_responder: one instance with CYCLE_DELAY=1
// driven from a vector table, one with CYCLE_DELAY=4 for multi-cycle cases.
module tb_ddr_mem_responder;
    localparam logic [255:0] A5 = {32{8'hA5}};
    localparam logic [255:0] P  = {8{32'h1234_5678}};
    localparam logic [255:0] Q  = {8{32'h0BAD_F00D}};
    localparam logic [255:0] W0 = {4{64'hDEAD_BEEF_0000_0001}};
    localparam logic [255:0] W1 = {8{32'hFFFF_0000}};
    localparam logic [255:0] W2 = {16{16'h5A5A}};

    typedef struct {
        logic         rw;
        logic [27:0]  addr;
        logic [255:0] data;
        logic [255:0] rd;
        logic [15:0]  wc;
        logic         oob;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] wc1, wc4;
    logic        oob1, oob4;
    int          pass = 0;
    int          total = 0;
    int          cyc = 0;

    ddr_mem_responder_if b1 ();
    ddr_mem_responder_if b4 ();

    ddr_mem_responder #(.CYCLE_DELAY(1), .DEPTH(1024)) u1 (
        .clk(clk), .rst(rst), .bus(b1), .wr_count(wc1), .oob_err(oob1)
    );
    ddr_mem_responder #(.CYCLE_DELAY(4), .DEPTH(1024)) u4 (
        .clk(clk), .rst(rst), .bus(b4), .wr_count(wc4), .oob_err(oob4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic drive(input int s, input logic v, input logic rw,
                         input logic [27:0] a, input logic [255:0] d);
        if (s == 1) begin
            b1.mem_valid_data1 = v; b1.mem_rw_data1 = rw;
            b1.mem_data_addr1 = a;  b1.mem_data_wr1 = d;
        end else begin
            b4.mem_valid_data1 = v; b4.mem_rw_data1 = rw;
            b4.mem_data_addr1 = a;  b4.mem_data_wr1 = d;
        end
    endtask

    task automatic set_valid(input int s, input logic v);
        if (s == 1) b1.mem_valid_data1 = v;
        else b4.mem_valid_data1 = v;
    endtask

    function automatic logic rdy(input int s);
        return (s == 1) ? b1.mem_ready_data1 : b4.mem_ready_data1;
    endfunction

    function automatic logic [255:0] rdd(input int s);
        return (s == 1) ? b1.mem_data_rd1 : b4.mem_data_rd1;
    endfunction

    // k = edges after the capture edge until ready is seen (bounded at 20)
    task automatic issue(input int s, input logic rw, input logic [27:0] a,
                         input logic [255:0] d, output int k,
                         output logic [255:0] rd);
        drive(s, 1'b1, rw, a, d);
        @(posedge clk); #1;
        set_valid(s, 1'b0);
        k = 0;
        while (!rdy(s) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        rd = rdd(s);
        @(posedge clk); #1;
        chk("ready_width", {255'd0, rdy(s)}, 256'd0);
    endtask

    vec_t         tbl[9];
    int           k;
    int           n;
    int           t[2];
    int           seen;
    logic [255:0] rd;
    logic [4:0]   pat;

    initial begin
        tbl[0] = '{1'b1, 28'h8,       A5,     256'd0, 16'd1, 1'b0};
        tbl[1] = '{1'b0, 28'h8,       256'd0, A5,     16'd1, 1'b0};
        tbl[2] = '{1'b0, 28'hC,       256'd0, A5,     16'd1, 1'b0};
        tbl[3] = '{1'b1, 28'h1FF8,    P,      A5,     16'd2, 1'b0};
        tbl[4] = '{1'b0, 28'h1FF8,    256'd0, P,      16'd2, 1'b0};
        tbl[5] = '{1'b0, 28'h2000,    256'd0, 256'd0, 16'd2, 1'b1};
        tbl[6] = '{1'b1, 28'h2000,    Q,      256'd0, 16'd3, 1'b1};
        tbl[7] = '{1'b0, 28'hFFFFFF8, 256'd0, 256'd0, 16'd3, 1'b1};
        tbl[8] = '{1'b0, 28'h8,       256'd0, A5,     16'd3, 1'b1};

        drive(1, 1'b0, 1'b0, 28'h0, 256'd0);
        drive(4, 1'b0, 1'b0, 28'h0, 256'd0);
        repeat (3) @(negedge clk);
        chk("rst_ready1", {255'd0, b1.mem_ready_data1}, 256'd0);
        chk("rst_rd1", b1.mem_data_rd1, 256'd0);
        chk("rst_wc1", {240'd0, wc1}, 256'd0);
        chk("rst_oob1", {255'd0, oob1}, 256'd0);
        chk("rst_ready4", {255'd0, b4.mem_ready_data1}, 256'd0);
        chk("rst_rd4", b4.mem_data_rd1, 256'd0);
        chk("rst_wc4", {240'd0, wc4}, 256'd0);
        chk("rst_oob4", {255'd0, oob4}, 256'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            issue(1, tbl[i].rw, tbl[i].addr, tbl[i].data, k, rd);
            chk($sformatf("v%0d_lat", i), 256'(k), 256'd0);
            chk($sformatf("v%0d_rd", i), rd, tbl[i].rd);
            chk($sformatf("v%0d_wc", i), {240'd0, wc1}, {240'd0, tbl[i].wc});
            chk($sformatf("v%0d_oob", i), {255'd0, oob1}, {255'd0, tbl[i].oob});
        end

        // Two-phase write with valid held high on the delay-4 instance
        drive(4, 1'b1, 1'b1, 28'h0, W0);
        n = 0;
        for (int i = 0; i < 30 && n < 2; i++) begin
            @(posedge clk); #1;
            if (b4.mem_ready_data1) begin
                t[n] = cyc;
                n++;
                if (n == 1) begin
                    b4.mem_data_addr1 = 28'h0C00000;
                    b4.mem_data_wr1   = W1;
                end else begin
                    b4.mem_valid_data1 = 1'b0;
                end
            end
        end
        b4.mem_valid_data1 = 1'b0;
        chk("tp_pulses", 256'(n), 256'd2);
        chk("tp_spacing", 256'(t[1] - t[0]), 256'd5);
        @(posedge clk); #1;
        chk("tp_ready_low", {255'd0, b4.mem_ready_data1}, 256'd0);
        chk("tp_wc", {240'd0, wc4}, 256'd2);
        chk("tp_oob", {255'd0, oob4}, 256'd1);
        issue(4, 1'b0, 28'h0, 256'd0, k, rd);
        chk("tp_lat", 256'(k), 256'd3);
        chk("tp_line0", rd, W0);

        // Delay-4 read with inputs toggled during WAIT
        drive(4, 1'b1, 1'b0, 28'h0, 256'd0);
        @(posedge clk); #1;
        chk("d4_k0", {255'd0, b4.mem_ready_data1}, 256'd0);
        pat = 5'b01000;
        rd = '0;
        for (int j = 1; j <= 4; j++) begin
            drive(4, j[0], ~j[0], 28'h0C00000 + 28'(j * 8), W1);
            @(posedge clk); #1;
            chk($sformatf("d4_k%0d", j), {255'd0, b4.mem_ready_data1},
                {255'd0, pat[j]});
            if (j == 3) rd = b4.mem_data_rd1;
        end
        set_valid(4, 1'b0);
        chk("d4_rd", rd, W0);
        chk("d4_wc", {240'd0, wc4}, 256'd2);

        // Reset in the middle of a delay-4 write
        drive(4, 1'b1, 1'b1, 28'h0, W2);
        @(posedge clk); #1;
        set_valid(4, 1'b0);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("mr_ready4", {255'd0, b4.mem_ready_data1}, 256'd0);
        chk("mr_rd4", b4.mem_data_rd1, 256'd0);
        chk("mr_wc4", {240'd0, wc4}, 256'd0);
        chk("mr_oob4", {255'd0, oob4}, 256'd0);
        chk("mr_rd1", b1.mem_data_rd1, 256'd0);
        chk("mr_wc1", {240'd0, wc1}, 256'd0);
        chk("mr_oob1", {255'd0, oob1}, 256'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (b4.mem_ready_data1 || b1.mem_ready_data1) seen++;
        end
        chk("mr_no_pulse", 256'(seen), 256'd0);
        issue(4, 1'b0, 28'h0, 256'd0, k, rd);
        chk("mr_lat", 256'(k), 256'd3);
        chk("mr_no_commit", rd, W0);
        chk("mr_wc_after", {240'd0, wc4}, 256'd0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
